// File: rtl/jsfq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jsfq_pkg
// Description : Shared types, default timing constants and helpers for the
//               cycle-accurate SFQ cell library (splitter / merger / JTL).
// Revision    : 1.0 - initial release
// ============================================================================
package jsfq_pkg;

    // Merger / splitter control state
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DEAD = 1'b1
    } state_t;

    // Library default timing, in clock cycles
    localparam int JSFQ_DELAY    = 4;
    localparam int JSFQ_PULSE_W  = 2;
    localparam int JSFQ_INTERVAL = 7;

    // Saturating add on up to 32-bit counters: returns min(a + inc, max_v).
    // Callers zero-extend their counter and truncate the result back.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] inc,
        input logic [31:0] max_v
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        if (sum > {1'b0, max_v}) begin
            return max_v;
        end
        return sum[31:0];
    endfunction

endpackage : jsfq_pkg
`default_nettype wire

// File: rtl/jsfq_pulse_line.sv
`default_nettype none
// ============================================================================
// Module      : jsfq_pulse_line
// Description : Fixed propagation delay plus output pulse stretcher. A trig
//               sampled high at edge t drives pulse high on edges
//               t+DELAY .. t+DELAY+PULSE_W-1. Triggers must be spaced by more
//               than PULSE_W cycles (guaranteed by the owning cell).
// Revision    : 1.0 - initial release
// ============================================================================
module jsfq_pulse_line #(
    parameter int DELAY   = 4,
    parameter int PULSE_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic pulse
);

    localparam int SW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(PULSE_W - 1);

    logic [DELAY-1:0] dly;
    logic [SW-1:0]    stretch;

    // Delay shift register feeding a registered pulse stretcher
    always_ff @(posedge clk) begin
        if (rst) begin
            dly     <= '0;
            stretch <= '0;
            pulse   <= 1'b0;
        end else begin
            dly[0] <= trig;
            for (int i = 1; i < DELAY; i++) begin
                dly[i] <= dly[i-1];
            end
            if (dly[DELAY-1]) begin
                pulse   <= 1'b1;
                stretch <= STRETCH_LOAD;
            end else if (stretch != '0) begin
                pulse   <= 1'b1;
                stretch <= stretch - 1'b1;
            end else begin
                pulse   <= 1'b0;
            end
        end
    end

endmodule : jsfq_pulse_line
`default_nettype wire

// File: rtl/jmrg3.sv
`default_nettype none
// ============================================================================
// Module      : jmrg3
// Description : SFQ 3-input merger (confluence buffer). Rising edges on
//               dinA/dinB/dinC are merged onto dout with a fixed delay, fixed
//               pulse width and a dead window of INTERVAL cycles between
//               accepted events. Accepted / rejected edges are counted with
//               saturation.
//               Optional macro JMRG3_QUEUE_EN: edges arriving in the dead
//               window are held in a 2-bit pending counter and replayed as
//               soon as the window closes instead of being dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module jmrg3
    import jsfq_pkg::*;
#(
    parameter int DELAY    = JSFQ_DELAY,
    parameter int PULSE_W  = JSFQ_PULSE_W,
    parameter int INTERVAL = JSFQ_INTERVAL,
    parameter int CNT_W    = 16           // 1..32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dinA,
    input  logic             dinB,
    input  logic             dinC,
    output logic             dout,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    localparam int DEAD_W = $clog2(INTERVAL);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(INTERVAL - 1);
    localparam logic [31:0] CNT_MAX =
        (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

    state_t            state;
    logic [DEAD_W-1:0] dead_cnt;
    logic              prev_a;
    logic              prev_b;
    logic              prev_c;
    logic [2:0]        edges;
    logic [1:0]        n_edges;
    logic              accept;
    logic [1:0]        drop_inc;

`ifdef JMRG3_QUEUE_EN
    logic [1:0]        pending;
    logic [1:0]        pend_next;
    logic [2:0]        pend_sum;
`endif

    assign edges   = {dinA & ~prev_a, dinB & ~prev_b, dinC & ~prev_c};
    assign n_edges = {1'b0, edges[0]} + {1'b0, edges[1]} + {1'b0, edges[2]};

    // Accept / drop decision for this cycle's edges
    always_comb begin
        accept   = 1'b0;
        drop_inc = 2'd0;
`ifdef JMRG3_QUEUE_EN
        pend_sum  = {1'b0, pending};
        pend_next = pending;
        if (state == IDLE) begin
            if (pending != 2'd0) begin
                // replay one queued event; any fresh edge joins the queue
                accept   = 1'b1;
                pend_sum = {1'b0, pending - 2'd1} + {1'b0, n_edges};
            end else if (n_edges != 2'd0) begin
                accept   = 1'b1;
                drop_inc = n_edges - 2'd1;
            end
        end else begin
            pend_sum = {1'b0, pending} + {1'b0, n_edges};
        end
        if (pend_sum > 3'd3) begin
            pend_next = 2'd3;
            drop_inc  = 2'(pend_sum - 3'd3);
        end else begin
            pend_next = pend_sum[1:0];
        end
`else
        if (state == IDLE) begin
            if (n_edges != 2'd0) begin
                accept   = 1'b1;
                drop_inc = n_edges - 2'd1;
            end
        end else begin
            drop_inc = n_edges;
        end
`endif
    end

    // Control FSM, edge history, dead-window timer and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dead_cnt <= '0;
            busy     <= 1'b0;
            prev_a   <= 1'b0;
            prev_b   <= 1'b0;
            prev_c   <= 1'b0;
            acc_cnt  <= '0;
            drop_cnt <= '0;
`ifdef JMRG3_QUEUE_EN
            pending  <= 2'd0;
`endif
        end else begin
            prev_a <= dinA;
            prev_b <= dinB;
            prev_c <= dinC;
            if (accept) begin
                state    <= DEAD;
                dead_cnt <= DEAD_LOAD;
                busy     <= 1'b1;
            end else if (state == DEAD) begin
                // the window closes on the cycle the timer reaches zero
                if (dead_cnt <= DEAD_W'(1)) begin
                    state    <= IDLE;
                    dead_cnt <= '0;
                    busy     <= 1'b0;
                end else begin
                    dead_cnt <= dead_cnt - 1'b1;
                end
            end
            acc_cnt  <= CNT_W'(sat_add(32'(acc_cnt), 32'(accept), CNT_MAX));
            drop_cnt <= CNT_W'(sat_add(32'(drop_cnt), 32'(drop_inc), CNT_MAX));
`ifdef JMRG3_QUEUE_EN
            pending  <= pend_next;
`endif
        end
    end

    jsfq_pulse_line #(
        .DELAY   (DELAY),
        .PULSE_W (PULSE_W)
    ) u_pulse_line (
        .clk   (clk),
        .rst   (rst),
        .trig  (accept),
        .pulse (dout)
    );

endmodule : jmrg3
`default_nettype wire

// File: tb/tb_jmrg3.sv
`default_nettype none
// ============================================================================
// Module      : tb_jmrg3
// Description : Directed scoreboard bench for the jmrg3 SFQ merger. A second
//               instance with 2-bit counters exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jmrg3;

    localparam int DELAY    = 4;
    localparam int PULSE_W  = 2;
    localparam int INTERVAL = 7;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        dinA = 1'b0;
    logic        dinB = 1'b0;
    logic        dinC = 1'b0;
    logic        dout;
    logic        busy;
    logic [15:0] acc_cnt;
    logic [15:0] drop_cnt;
    logic        dout_s;
    logic        busy_s;
    logic [1:0]  acc_s;
    logic [1:0]  drop_s;

    int n_vec  = 0;
    int n_err  = 0;
    int edge_n = 0;
    int exp_q[$];
    int hi_len = 0;
    logic dout_q = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    jmrg3 #(.DELAY(DELAY), .PULSE_W(PULSE_W), .INTERVAL(INTERVAL), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .dinA(dinA), .dinB(dinB), .dinC(dinC),
        .dout(dout), .acc_cnt(acc_cnt), .drop_cnt(drop_cnt), .busy(busy)
    );

    jmrg3 #(.DELAY(DELAY), .PULSE_W(PULSE_W), .INTERVAL(INTERVAL), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .dinA(dinA), .dinB(dinB), .dinC(dinC),
        .dout(dout_s), .acc_cnt(acc_s), .drop_cnt(drop_s), .busy(busy_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply v={A,B,C} for the next sample edge; t returns that edge's index.
    task automatic drive(input logic [2:0] v, output int t);
        @(negedge clk);
        {dinA, dinB, dinC} = v;
        t = edge_n + 1;
    endtask

    task automatic idle(input int n);
        int t;
        repeat (n) drive(3'b000, t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {dinA, dinB, dinC} = 3'b000;
        @(negedge clk);
        @(negedge clk);
        check("rst_dout", 32'(dout), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_acc",  32'(acc_cnt), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic end_test(input string tag);
        check({tag, "_missing_pulses"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    // Output monitor: pulse start times come from the scoreboard queue
    always @(negedge clk) begin
        int exp_t;
        if (rst) begin
            hi_len = 0;
            dout_q = 1'b0;
        end else begin
            if (dout === 1'b1 && dout_q === 1'b0) begin
                exp_t = (exp_q.size() == 0) ? -1 : exp_q.pop_front();
                check("pulse_start", 32'(edge_n), 32'(exp_t));
            end
            if (dout === 1'b1) begin
                hi_len++;
            end else if (dout_q === 1'b1) begin
                check("pulse_width", 32'(hi_len), 32'(PULSE_W));
                hi_len = 0;
            end
            dout_q = dout;
        end
    end

    initial begin
        int t;
        int t2;

        // single edge, busy window
        do_reset();
        drive(3'b100, t); exp_q.push_back(t + DELAY);
        drive(3'b000, t2);
        check("t1_busy_set", 32'(busy), 1);
        idle(6);
        check("t1_busy_clr", 32'(busy), 0);
        idle(14);
        check("t1_acc",  32'(acc_cnt), 1);
        check("t1_drop", 32'(drop_cnt), 0);
        end_test("t1");

        // edge at t+INTERVAL-1 rejected, edge at t+INTERVAL accepted
        do_reset();
        drive(3'b100, t); exp_q.push_back(t + DELAY);
        idle(5);
        drive(3'b010, t2);
        drive(3'b001, t2);
`ifdef JMRG3_QUEUE_EN
        exp_q.push_back(t + INTERVAL + DELAY);
        exp_q.push_back(t + 2 * INTERVAL + DELAY);
        idle(30);
        check("t2_acc",  32'(acc_cnt), 3);
        check("t2_drop", 32'(drop_cnt), 0);
`else
        exp_q.push_back(t2 + DELAY);
        idle(30);
        check("t2_acc",  32'(acc_cnt), 2);
        check("t2_drop", 32'(drop_cnt), 1);
`endif
        end_test("t2");

        // three coincident edges
        do_reset();
        drive(3'b111, t); exp_q.push_back(t + DELAY);
        idle(20);
        check("t3_acc",  32'(acc_cnt), 1);
        check("t3_drop", 32'(drop_cnt), 2);
        end_test("t3");

        // level held high for 30 cycles
        do_reset();
        drive(3'b100, t); exp_q.push_back(t + DELAY);
        repeat (29) drive(3'b100, t2);
        idle(20);
        check("t4_acc",  32'(acc_cnt), 1);
        check("t4_drop", 32'(drop_cnt), 0);
        end_test("t4");

        // reset while a pulse is in flight
        do_reset();
        drive(3'b100, t);
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_dout", 32'(dout), 0);
        check("t5_acc",  32'(acc_cnt), 0);
        check("t5_drop", 32'(drop_cnt), 0);
        check("t5_busy", 32'(busy), 0);
        rst = 1'b0;
        idle(12);
        check("t5_acc_after", 32'(acc_cnt), 0);
        end_test("t5");

        // edges at t, t+2, t+3 on different inputs
        do_reset();
        drive(3'b100, t); exp_q.push_back(t + DELAY);
        drive(3'b000, t2);
        drive(3'b010, t2);
        drive(3'b001, t2);
`ifdef JMRG3_QUEUE_EN
        exp_q.push_back(t + INTERVAL + DELAY);
        exp_q.push_back(t + 2 * INTERVAL + DELAY);
        idle(30);
        check("t6_acc",  32'(acc_cnt), 3);
        check("t6_drop", 32'(drop_cnt), 0);
`else
        idle(30);
        check("t6_acc",  32'(acc_cnt), 1);
        check("t6_drop", 32'(drop_cnt), 2);
`endif
        end_test("t6");

        // six isolated 3-way coincidences: saturation on the 2-bit instance
        do_reset();
        repeat (6) begin
            drive(3'b111, t); exp_q.push_back(t + DELAY);
            idle(9);
        end
        idle(10);
        check("t7_acc",    32'(acc_cnt), 6);
        check("t7_drop",   32'(drop_cnt), 12);
        check("t7_acc_s",  32'(acc_s), 3);
        check("t7_drop_s", 32'(drop_s), 3);
        end_test("t7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_jmrg3
`default_nettype wire

// File: doc/jmrg3.md
Name: jmrg3

Overview:
- Cycle-accurate model of an SFQ 3-input merger (confluence buffer), the fan-in counterpart of the 3-way splitter cell.
- Combines pulse streams dinA/dinB/dinC onto one output dout.
- Applies fixed propagation delay, fixed output pulse width and a minimum inter-pulse interval; reports accepted and rejected pulse counts.
- Sits in the SFQ cell library beside the splitter; used to recombine fanned-out pulse trains in netlist-level simulation.

Parameters:
- DELAY, 4, cycles from accepted input edge to dout rising (>=1).
- PULSE_W, 2, cycles dout stays high per event (>=1).
- INTERVAL, 7, minimum cycles between accepted events (>= PULSE_W+1).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- dinA  input  1  pulse input A; event = rising edge (0 then 1 on consecutive samples).
- dinB  input  1  pulse input B; same rule.
- dinC  input  1  pulse input C; same rule.
- dout  output  1  merged pulse output, registered.
- acc_cnt  output  CNT_W  accepted events, saturating.
- drop_cnt  output  CNT_W  rejected input edges, saturating.
- busy  output  1  high while the dead window is active.

Behaviour:
- Reset: rst sampled high clears dout=0, acc_cnt=0, drop_cnt=0, busy=0, delay line, stretch counter and edge-detect history (prev=0); state=IDLE.
- Reset mid-operation: any in-flight pulse is discarded; dout is 0 from the first edge with rst high.
- Edge detect: prevX <= dinX each cycle; edgeX = dinX & ~prevX. A level held high produces one event only.
- FSM states:
  - IDLE: any edge at sample edge t -> accept one event, acc_cnt+1, load dead counter with INTERVAL-1, go DEAD (busy=1 from t).
  - DEAD: dead counter decrements each cycle; every edge seen counts as a drop (drop_cnt += number of edges that cycle, 1..3). At 0 -> IDLE. An edge at t+INTERVAL is accepted; an edge at t+INTERVAL-1 is dropped.
- Coincidence: in IDLE, k>1 simultaneous edges -> one event accepted, acc_cnt+1, drop_cnt+(k-1).
- Output: accepted at edge t -> dout=1 on edges t+DELAY .. t+DELAY+PULSE_W-1, else 0. INTERVAL > PULSE_W guarantees no overlap and no re-trigger.
- Counters: saturate at 2^CNT_W-1; never wrap. drop_cnt adds up to 3 in one cycle, clamped at max.

Optional Feature:
- Macro JMRG3_QUEUE_EN.
- Defined:
  - Edges rejected in DEAD increment a 2-bit pending counter (max 3) instead of drop_cnt.
  - Edges beyond the cap go to drop_cnt.
  - When DEAD expires with pending>0, a queued event is accepted in that same cycle (pending-1, acc_cnt+1, DEAD reloaded).
  - A fresh edge in that cycle is also queued.
  - Reset clears pending.
- Undefined: no pending register; behaviour exactly as above.

Decomposition:
- Package jsfq_pkg:
  - state enum (IDLE, DEAD);
  - default constants JSFQ_DELAY, JSFQ_PULSE_W, JSFQ_INTERVAL;
  - saturating-add function shared with other SFQ cells.
- Sub-module jsfq_pulse_line: DELAY-stage shift register plus PULSE_W stretch counter, parameterised, synchronous reset. Reusable by splitter/merger/JTL cells.

Test Plan:
- Reset then single dinA edge at edge 10 -> dout high at edges 14-15 only; acc_cnt=1, drop_cnt=0.
- dinA edge at 10, dinB edge at 16 -> only one output (14-15); drop_cnt=1. dinC edge at 17 -> accepted, dout high 21-22; acc_cnt=2.
- dinA, dinB, dinC rising together at 20 -> one pulse at 24-25; acc_cnt=1, drop_cnt=2.
- dinA held high 30 cycles -> exactly one output pulse; acc_cnt=1.
- Accepted edge at 10, rst high at 13 -> dout stays 0 through 20; all counters 0.
- With JMRG3_QUEUE_EN: edges at 10, 12, 13 -> pulses start at 14, 21, 28; acc_cnt=3, drop_cnt=0. Under CNT_W=2, six isolated events -> acc_cnt sticks at 3.
